// File: rtl/rx_edge_bit_sampler.sv
// rx_edge_bit_sampler
//
// Oversampling timing and data-recovery stage of the UART receiver. While the
// RX control FSM holds S_EN high, this block counts oversampling clocks within
// each bit period (edge_count) and counts completed bit periods (bit_count). It
// recovers each serial bit from samples taken around mid-bit and issues a
// one-cycle 'sampled' strobe with the recovered value on 'sampled_bit'.
//
// Build option:
//   RX_MAJORITY_VOTE_EN  defined   : decided bit is the 2-of-3 majority of the
//                                    samples at mid-1, mid and mid+1.
//                        undefined : decided bit is the single sample at mid.
//
// Ports:
//   CLK          in   receiver oversampling clock
//   Reset        in   synchronous, active-high reset
//   S_EN         in   sampler enable; low holds counters cleared
//   S_Data       in   serial line, already synchronized to CLK
//   Prescale     in   clocks per bit (8, 16, 32); bit 0 ignored, min 8
//   sampled      out  one-cycle strobe: new bit value on sampled_bit
//   sampled_bit  out  recovered bit value, held until the next strobe
//   bit_count    out  completed bit periods since enable, saturates at 15
//   edge_count   out  oversampling position within the current bit, 0..P-1

module rx_edge_bit_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  S_EN,
  input  logic                  S_Data,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  sampled,
  output logic                  sampled_bit,
  output logic [3:0]            bit_count,
  output logic [PRESCALE_W-1:0] edge_count
);

  typedef enum logic {
    DISABLED = 1'b0,
    COUNTING = 1'b1
  } mode_t;

  localparam logic [PRESCALE_W-1:0] ONE          = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] MIN_PRESCALE = PRESCALE_W'(8);
  localparam logic [3:0]            BIT_COUNT_MAX = 4'd15;

  mode_t                  mode;
  logic [PRESCALE_W-1:0]  prescale_even;
  logic [PRESCALE_W-1:0]  prescale_clamped;
  logic [PRESCALE_W-1:0]  period;
  logic [PRESCALE_W-1:0]  mid;
  logic [PRESCALE_W-1:0]  last_edge;
  logic                   at_mid;
  logic                   at_decide;
  logic                   at_period_end;
  logic                   decided_bit;
  logic                   s1;

  // The enable is the whole state: the block is either cleared or counting,
  // and the choice is made from the current S_EN on every edge.
  assign mode = S_EN ? COUNTING : DISABLED;

  // Odd prescale values are rounded down and anything below 8 is forced to 8,
  // so the three mid-bit sample positions always fit before the period wraps.
  assign prescale_even    = {Prescale[PRESCALE_W-1:1], 1'b0};
  assign prescale_clamped = (prescale_even < MIN_PRESCALE) ? MIN_PRESCALE : prescale_even;

  assign mid           = period >> 1;
  assign last_edge     = period - ONE;
  assign at_mid        = (edge_count == mid);
  assign at_decide     = (edge_count == (mid + ONE));
  assign at_period_end = (edge_count == last_edge);

`ifdef RX_MAJORITY_VOTE_EN
  logic s0;
  logic at_early;

  assign at_early = (edge_count == (mid - ONE));

  // The third sample is the live line value on the decision edge, so the
  // vote completes in the same cycle the last sample is taken.
  assign decided_bit = (s0 & s1) | (s0 & S_Data) | (s1 & S_Data);

  // Early sample, one clock before mid-bit.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      s0 <= 1'b1;
    end else if ((mode == COUNTING) && at_early) begin
      s0 <= S_Data;
    end
  end
`else
  assign decided_bit = s1;
`endif

  // Period latch, counters, mid-bit sample and strobe. The period only tracks
  // Prescale while disabled so a frame in progress keeps a constant bit time.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      period      <= prescale_clamped;
      edge_count  <= '0;
      bit_count   <= '0;
      sampled     <= 1'b0;
      sampled_bit <= 1'b1;
      s1          <= 1'b1;
    end else begin
      case (mode)
        DISABLED: begin
          period     <= prescale_clamped;
          edge_count <= '0;
          bit_count  <= '0;
          sampled    <= 1'b0;
        end
        COUNTING: begin
          if (at_period_end) begin
            edge_count <= '0;
            if (bit_count != BIT_COUNT_MAX) begin
              bit_count <= bit_count + 4'd1;
            end
          end else begin
            edge_count <= edge_count + ONE;
          end

          if (at_mid) begin
            s1 <= S_Data;
          end

          if (at_decide) begin
            sampled_bit <= decided_bit;
            sampled     <= 1'b1;
          end else begin
            sampled     <= 1'b0;
          end
        end
        default: begin
          sampled <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_edge_bit_sampler.sv
// tb_rx_edge_bit_sampler
//
// Self-checking bench for rx_edge_bit_sampler. A time-based reference model
// (elapsed enabled clocks, period arithmetic, remembered line values) predicts
// every output each cycle; directed scenarios add hand-computed literal checks.

module tb_rx_edge_bit_sampler;

`ifdef RX_MAJORITY_VOTE_EN
  localparam bit MAJORITY_EN = 1'b1;
`else
  localparam bit MAJORITY_EN = 1'b0;
`endif

  logic       CLK;
  logic       Reset;
  logic       S_EN;
  logic       S_Data;
  logic [5:0] Prescale;
  logic       sampled;
  logic       sampled_bit;
  logic [3:0] bit_count;
  logic [5:0] edge_count;

  int n_tests;
  int n_fails;
  int cyc;
  bit checking;
  bit recording;
  int strobe_cycles[$];
  int strobe_bits[$];

  // Reference model state: elapsed enabled clocks, latched period, and
  // the remembered line values at the sample points.
  int t_model;
  int p_model;
  int v0_model;
  int v1_model;
  int bit_model;
  int sampled_model;

  rx_edge_bit_sampler #(.PRESCALE_W(6)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .S_EN       (S_EN),
    .S_Data     (S_Data),
    .Prescale   (Prescale),
    .sampled    (sampled),
    .sampled_bit(sampled_bit),
    .bit_count  (bit_count),
    .edge_count (edge_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int clamp_period(input int pre);
    int e;
    e = pre - (pre % 2);
    if (e < 8) e = 8;
    return e;
  endfunction

  // Reference model: position inside a bit is elapsed time modulo the period.
  always @(posedge CLK) begin
    int pos;
    int half;
    cyc++;
    if (Reset) begin
      t_model       = 0;
      p_model       = clamp_period(int'(Prescale));
      bit_model     = 1;
      sampled_model = 0;
      v0_model      = 1;
      v1_model      = 1;
    end else if (!S_EN) begin
      t_model       = 0;
      p_model       = clamp_period(int'(Prescale));
      sampled_model = 0;
    end else begin
      pos  = t_model % p_model;
      half = p_model / 2;
      sampled_model = 0;
      if (pos == half - 1) v0_model = int'(S_Data);
      if (pos == half)     v1_model = int'(S_Data);
      if (pos == half + 1) begin
        if (MAJORITY_EN)
          bit_model = (v0_model + v1_model + int'(S_Data)) >= 2 ? 1 : 0;
        else
          bit_model = v1_model;
        sampled_model = 1;
      end
      t_model++;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    int exp_edge;
    int exp_bits;
    if (checking) begin
      exp_edge = t_model % p_model;
      exp_bits = (t_model / p_model) > 15 ? 15 : (t_model / p_model);
      n_tests += 4;
      if (int'(edge_count) != exp_edge) begin
        n_fails++;
        $display("[TB] FAIL cyc%0d edge_count: got %0d expected %0d", cyc, edge_count, exp_edge);
      end
      if (int'(bit_count) != exp_bits) begin
        n_fails++;
        $display("[TB] FAIL cyc%0d bit_count: got %0d expected %0d", cyc, bit_count, exp_bits);
      end
      if (int'(sampled) != sampled_model) begin
        n_fails++;
        $display("[TB] FAIL cyc%0d sampled: got %0d expected %0d", cyc, sampled, sampled_model);
      end
      if (int'(sampled_bit) != bit_model) begin
        n_fails++;
        $display("[TB] FAIL cyc%0d sampled_bit: got %0d expected %0d", cyc, sampled_bit, bit_model);
      end
    end
  end

  // Strobe recorder for the frame scenario.
  always @(negedge CLK) begin
    if (recording && sampled) begin
      strobe_cycles.push_back(cyc);
      strobe_bits.push_back(int'(sampled_bit));
    end
  end

  task automatic applyStimulus(input logic en, input logic d, input logic [5:0] pre, input int n);
    S_EN     = en;
    S_Data   = d;
    Prescale = pre;
    repeat (n) @(negedge CLK);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  initial begin
    logic frame [10];
    frame = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    n_tests   = 0;
    n_fails   = 0;
    cyc       = 0;
    recording = 1'b0;
    Reset     = 1'b1;
    S_EN      = 1'b0;
    S_Data    = 1'b1;
    Prescale  = 6'd8;
    checking  = 1'b1;

    // Reset values
    repeat (2) @(negedge CLK);
    checkOutput("reset sampled", int'(sampled), 0);
    checkOutput("reset sampled_bit", int'(sampled_bit), 1);
    checkOutput("reset bit_count", int'(bit_count), 0);
    checkOutput("reset edge_count", int'(edge_count), 0);
    Reset = 1'b0;

    // P=8, line low for one bit: strobe while edge_count=6, then wrap
    applyStimulus(1'b0, 1'b1, 6'd8, 1);
    applyStimulus(1'b1, 1'b0, 6'd8, 6);
    checkOutput("p8 strobe edge_count", int'(edge_count), 6);
    checkOutput("p8 strobe sampled", int'(sampled), 1);
    checkOutput("p8 strobe bit", int'(sampled_bit), 0);
    applyStimulus(1'b1, 1'b0, 6'd8, 2);
    checkOutput("p8 wrap edge_count", int'(edge_count), 0);
    checkOutput("p8 wrap bit_count", int'(bit_count), 1);
    checkOutput("p8 wrap sampled", int'(sampled), 0);
    // Disable mid-bit, before the strobe of bit 1
    applyStimulus(1'b1, 1'b1, 6'd8, 3);
    applyStimulus(1'b0, 1'b1, 6'd8, 1);
    checkOutput("disable edge_count", int'(edge_count), 0);
    checkOutput("disable bit_count", int'(bit_count), 0);
    applyStimulus(1'b0, 1'b1, 6'd8, 4);
    checkOutput("disable no strobe", int'(sampled), 0);

    // P=16 frame 0_10110011_1
    applyStimulus(1'b0, 1'b1, 6'd16, 1);
    strobe_cycles.delete();
    strobe_bits.delete();
    recording = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, frame[i], 6'd16, 16);
    recording = 1'b0;
    checkOutput("frame strobe count", strobe_bits.size(), 10);
    checkOutput("frame bit_count", int'(bit_count), 10);
    checkOutput("frame edge_count", int'(edge_count), 0);
    for (int i = 0; i < 10 && i < strobe_bits.size(); i++) begin
      checkOutput($sformatf("frame bit%0d", i), strobe_bits[i], int'(frame[i]));
      if (i > 0) checkOutput($sformatf("frame spacing%0d", i), strobe_cycles[i] - strobe_cycles[i-1], 16);
    end

    // Single-cycle glitch low exactly at mid-bit index 4 (P=8)
    applyStimulus(1'b0, 1'b1, 6'd8, 1);
    applyStimulus(1'b1, 1'b1, 6'd8, 4);
    applyStimulus(1'b1, 1'b0, 6'd8, 1);
    applyStimulus(1'b1, 1'b1, 6'd8, 1);
    checkOutput("glitch sampled", int'(sampled), 1);
    checkOutput("glitch bit", int'(sampled_bit), MAJORITY_EN ? 1 : 0);

    // Prescale change 16 -> 8 while enabled: period stays 16
    applyStimulus(1'b0, 1'b1, 6'd16, 1);
    applyStimulus(1'b1, 1'b1, 6'd16, 5);
    applyStimulus(1'b1, 1'b1, 6'd8, 3);
    checkOutput("frozen p edge_count 8", int'(edge_count), 8);
    checkOutput("frozen p bit_count 0", int'(bit_count), 0);
    applyStimulus(1'b1, 1'b1, 6'd8, 8);
    checkOutput("frozen p wrap edge", int'(edge_count), 0);
    checkOutput("frozen p wrap bits", int'(bit_count), 1);
    applyStimulus(1'b0, 1'b1, 6'd8, 1);
    applyStimulus(1'b1, 1'b1, 6'd8, 8);
    checkOutput("new p edge_count", int'(edge_count), 0);
    checkOutput("new p bit_count", int'(bit_count), 1);

    // Reset pulse at edge_count=5 of bit 3 (the decision edge for P=8)
    applyStimulus(1'b0, 1'b0, 6'd8, 1);
    applyStimulus(1'b1, 1'b0, 6'd8, 29);
    checkOutput("pre-reset bit_count", int'(bit_count), 3);
    checkOutput("pre-reset edge_count", int'(edge_count), 5);
    checkOutput("pre-reset sampled_bit", int'(sampled_bit), 0);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    checkOutput("mid reset sampled", int'(sampled), 0);
    checkOutput("mid reset sampled_bit", int'(sampled_bit), 1);
    checkOutput("mid reset bit_count", int'(bit_count), 0);
    checkOutput("mid reset edge_count", int'(edge_count), 0);
    applyStimulus(1'b1, 1'b0, 6'd8, 3);
    checkOutput("restart edge_count", int'(edge_count), 3);
    checkOutput("restart bit_count", int'(bit_count), 0);

    // 20 bit periods at P=8: bit_count saturates
    applyStimulus(1'b0, 1'b1, 6'd8, 1);
    applyStimulus(1'b1, 1'b1, 6'd8, 160);
    checkOutput("saturate bit_count", int'(bit_count), 15);
    checkOutput("saturate edge_count", int'(edge_count), 0);

    // Prescale=3 clamps to 8; Prescale=17 drops bit 0 to 16
    applyStimulus(1'b0, 1'b1, 6'd3, 1);
    applyStimulus(1'b1, 1'b1, 6'd3, 7);
    checkOutput("clamp edge_count 7", int'(edge_count), 7);
    applyStimulus(1'b1, 1'b1, 6'd3, 1);
    checkOutput("clamp wrap edge", int'(edge_count), 0);
    checkOutput("clamp wrap bits", int'(bit_count), 1);
    applyStimulus(1'b0, 1'b1, 6'd17, 1);
    applyStimulus(1'b1, 1'b1, 6'd17, 16);
    checkOutput("odd p wrap edge", int'(edge_count), 0);
    checkOutput("odd p wrap bits", int'(bit_count), 1);

    applyStimulus(1'b0, 1'b1, 6'd8, 2);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
